// File: rtl/mutative_miss_classifier.sv
// Miss classifier: shadow fully-associative LRU directory beside the real cache,
// registering hit/full flags per request. Statistics counters need MUTATIVE_MISS_STATS_EN.
module mutative_miss_classifier #(
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 5,
    parameter int NUM_LINES   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_req,
    input  logic [ADDR_WIDTH-1:0]       cpu_addr,
    input  logic                        rc_line_valid,
    input  logic                        rc_hit,
    input  logic                        rc_full,
    input  logic                        cache_ready,
    output logic                        real_cache_valid,
    output logic                        real_cache_hit,
    output logic                        full_assoc_hit,
    output logic                        real_cache_full,
    output logic                        full_assoc_full,
    output logic [31:0]                 access_count,
    output logic [31:0]                 conflict_count,
    output logic [31:0]                 capacity_count,
    output logic [1:0]                  state,
    output logic [$clog2(NUM_LINES):0]  valid_count
);

    localparam int TW = ADDR_WIDTH - OFFSET_BITS;
    localparam int AW = $clog2(NUM_LINES);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [NUM_LINES-1:0] ent_valid;
    logic [TW-1:0]        ent_tag [NUM_LINES];
    logic [AW-1:0]        ent_age [NUM_LINES];

    logic [TW-1:0] line_q;
    logic [AW-1:0] hit_idx_q;
    logic [TW-1:0] req_line;
    logic          cmp_hit;
    logic [AW-1:0] cmp_idx;
    logic [AW-1:0] free_idx;
    logic [AW-1:0] victim_idx;
    logic          capture;
    logic          unused_offset;

    assign req_line      = cpu_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_offset = ^cpu_addr[OFFSET_BITS-1:0];
    assign capture       = (state == S_IDLE) && cpu_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (cpu_req) state <= S_UPDATE;
                S_UPDATE: state <= S_WAIT;
                S_WAIT:   if (cache_ready) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Parallel tag compare plus lowest-free and LRU-victim searches.
    always_comb begin
        cmp_hit    = 1'b0;
        cmp_idx    = '0;
        free_idx   = '0;
        victim_idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_tag[i] == req_line)) begin
                cmp_hit = 1'b1;
                cmp_idx = AW'(i);
            end
            if (!ent_valid[i]) free_idx = AW'(i);
            if (ent_age[i] == AW'(NUM_LINES - 1)) victim_idx = AW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            real_cache_valid <= 1'b0;
            real_cache_hit   <= 1'b0;
            real_cache_full  <= 1'b0;
            full_assoc_hit   <= 1'b0;
            full_assoc_full  <= 1'b0;
            line_q           <= '0;
            hit_idx_q        <= '0;
        end else if (capture) begin
            real_cache_valid <= rc_line_valid;
            real_cache_hit   <= rc_hit;
            real_cache_full  <= rc_full;
            full_assoc_hit   <= cmp_hit;
            full_assoc_full  <= (valid_count == CW'(NUM_LINES));
            line_q           <= req_line;
            hit_idx_q        <= cmp_idx;
        end
    end

    // Directory update uses only the captured flags; ages remain a permutation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                ent_valid[i] <= 1'b0;
                ent_tag[i]   <= '0;
                ent_age[i]   <= '0;
            end
            valid_count <= '0;
        end else if (state == S_UPDATE) begin
            if (full_assoc_hit) begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    if (ent_valid[i] && (ent_age[i] < ent_age[hit_idx_q]))
                        ent_age[i] <= ent_age[i] + 1'b1;
                end
                ent_age[hit_idx_q] <= '0;
            end else if (!full_assoc_full) begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    if (AW'(i) == free_idx) begin
                        ent_valid[i] <= 1'b1;
                        ent_tag[i]   <= line_q;
                        ent_age[i]   <= '0;
                    end else if (ent_valid[i]) begin
                        ent_age[i] <= ent_age[i] + 1'b1;
                    end
                end
                valid_count <= valid_count + 1'b1;
            end else begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    if (AW'(i) == victim_idx) begin
                        ent_tag[i] <= line_q;
                        ent_age[i] <= '0;
                    end else begin
                        ent_age[i] <= ent_age[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef MUTATIVE_MISS_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_count   <= '0;
            conflict_count <= '0;
            capacity_count <= '0;
        end else if ((state == S_UPDATE) && real_cache_valid) begin
            access_count <= access_count + 32'd1;
            if (!real_cache_hit && (full_assoc_hit || !real_cache_full))
                conflict_count <= conflict_count + 32'd1;
            if (!real_cache_hit && !full_assoc_hit && real_cache_full && full_assoc_full)
                capacity_count <= capacity_count + 32'd1;
        end
    end
`else
    assign access_count   = '0;
    assign conflict_count = '0;
    assign capacity_count = '0;
`endif

endmodule

// File: doc/mutative_miss_classifier.md
# mutative_miss_classifier

Producer side of the mutative-cache miss-classification interface. Tracks a shadow fully-associative LRU directory with the same line count as the real cache, snapshots the real cache's lookup status on each CPU request, and drives the five classification flags consumed by `mutative_control`. Sits beside the real cache and takes the same `cpu_req`/`cache_ready` handshake. The associativity controller sees registered, stable flags in the cycle after the request.

## Interface
- `ADDR_WIDTH`, default 32: CPU byte-address width.
- `OFFSET_BITS`, default 5: line-offset bits. Line address is `cpu_addr[ADDR_WIDTH-1:OFFSET_BITS]`.
- `NUM_LINES`, default 16: shadow entries. Power of two, at least 2. Equals the real-cache line count.
- `clk` in 1: the block's only clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cpu_req` in 1: CPU access request. Sampled only in S_IDLE.
- `cpu_addr` in ADDR_WIDTH: request address. Valid while `cpu_req` is high.
- `rc_line_valid` in 1: valid bit of the real-cache line indexed by `cpu_addr`. Valid with `cpu_req`.
- `rc_hit` in 1: real-cache hit for `cpu_addr`. Valid with `cpu_req`.
- `rc_full` in 1: every real-cache line is valid. Valid with `cpu_req`.
- `cache_ready` in 1: real cache has completed the access.
- `real_cache_valid` out 1: registered copy of `rc_line_valid`.
- `real_cache_hit` out 1: registered copy of `rc_hit`.
- `full_assoc_hit` out 1: line address was present in the shadow directory before this access.
- `real_cache_full` out 1: registered copy of `rc_full`.
- `full_assoc_full` out 1: all shadow entries were valid before this access.
- `access_count`, `conflict_count`, `capacity_count` out 32 each: statistics outputs (see Configuration).

## Operation
- States:
  - S_IDLE: on `cpu_req`, go to S_UPDATE. Otherwise stay.
  - S_UPDATE: always go to S_WAIT next cycle.
  - S_WAIT: when `cache_ready` is high, go to S_IDLE.
- Capture (S_IDLE with `cpu_req` high):
  - Register the line address.
  - Register the three `rc_*` inputs into their outputs.
  - Register `full_assoc_hit` from a parallel tag compare against all valid shadow entries.
  - Register `full_assoc_full` as `valid_count == NUM_LINES`.
  - Also register the hit index.
- Flags hold their values until the next capture. They are never cleared between requests.
- Shadow directory: per entry, a valid bit, a line tag, and a `$clog2(NUM_LINES)`-bit age. Age 0 is MRU.
- Shadow update happens at the end of S_UPDATE, using only the registered capture values:
  - Hit at entry h: entries with age < age[h] increment; age[h] is set to 0.
  - Miss, not full: write the lowest-index invalid entry with valid=1, the tag, and age 0. All other valid entries increment. `valid_count` increments.
  - Miss, full: the victim is the unique entry with age NUM_LINES-1. Overwrite its tag and set its age to 0. All others increment.
- Ages stay a permutation of 0..valid_count-1 at all times. No age ever saturates or wraps.
- `cpu_req` in S_UPDATE or S_WAIT is ignored: no capture and no shadow change.

## Timing
- Reset values:
  - State S_IDLE.
  - All five flags 0.
  - All shadow entries invalid, all ages 0, `valid_count` 0.
  - All statistics counters 0.
- Reset asserted mid-operation clears everything immediately, including any shadow update that has not yet been applied.
- Flag latency: flags are valid one cycle after the `cpu_req` edge, i.e. throughout S_UPDATE, which is the cycle `mutative_control` samples them.
- Shadow latency: the update is visible to a compare two cycles after the `cpu_req` edge.
- Minimum request spacing is 3 cycles (S_IDLE → S_UPDATE → S_WAIT → S_IDLE).
- A `cache_ready` already high in S_WAIT's first cycle exits S_WAIT after exactly one cycle.
- A `cache_ready` pulse seen during S_UPDATE is not remembered.

## Configuration
- Macro `MUTATIVE_MISS_STATS_EN` enables the statistics counters.
- Defined: on each S_UPDATE (only when `real_cache_valid` is 1):
  - `access_count` +1.
  - `conflict_count` +1 when `!rc_hit && (fa_hit || !rc_full)`.
  - `capacity_count` +1 when `!rc_hit && !fa_hit && rc_full && fa_full`.
  - All counters wrap modulo 2^32.
- Undefined: no counter logic; all three outputs are tied to 0.

## Test plan
- Reset, then idle 10 cycles → all flags 0, state S_IDLE, `valid_count` 0.
- Request addr 0x100 with rc_hit=0, rc_line_valid=1, rc_full=0, cache_ready 2 cycles later → S_UPDATE flags (1,0,0,0,0). Repeat 0x100 → `full_assoc_hit` 1.
- Touch NUM_LINES=16 distinct lines 0x000..0x1E0 (stride 0x20) → next request sees `full_assoc_full` 1. Line 0x200 misses, evicts 0x000; a following 0x000 gives `full_assoc_hit` 0.
- After the fill, re-touch 0x000, then access 0x200 → 0x020 is evicted instead; 0x000 still hits.
- Pulse `cpu_req` with addr 0x300 during S_WAIT → no capture, flags unchanged, 0x300 absent afterwards.
- With `MUTATIVE_MISS_STATS_EN`: one conflict case and one capacity case, both with rc_line_valid=1 → access 2, conflict 1, capacity 1. Without the macro → all three counters 0.
